// File: rtl/sa_pkg.sv
// ---------------------------------------------------------------------------
// sa_pkg
// Shared types and constants for the 4x4 systolic-array sequencer.
//   sa_state_t    : sequencer FSM states
//   SA_DIM        : array edge (PEs per row/column)
//   SA_SKEW       : extra feed cycles needed to drain the operand skew
//   SA_RES_PER_OP : results committed to output memory per operation
//   SA_*_W        : default widths for K, instruction address, operand
//                   column pointer and output-memory base address
// ---------------------------------------------------------------------------
package sa_pkg;

  localparam int SA_DIM        = 4;
  localparam int SA_SKEW       = 2 * (SA_DIM - 1);
  localparam int SA_RES_PER_OP = SA_DIM * SA_DIM;

  localparam int SA_K_W        = 4;
  localparam int SA_IADDR_W    = 3;
  localparam int SA_COL_W      = 8;
  localparam int SA_OADDR_W    = 7;
  localparam int SA_PERF_W     = 16;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_FETCH,
    ST_DECODE,
    ST_CLEAR,
    ST_FEED,
    ST_LAST,
    ST_WRITE,
    ST_DONE
  } sa_state_t;

endpackage

// File: rtl/sa_perf_counter.sv
// ---------------------------------------------------------------------------
// sa_perf_counter
// Saturating enable counter used to measure busy cycles of the sequencer.
// Only present when the SA_PERF_CNT_EN macro is defined; without it the
// sequencer ties its perf_cycles output to zero and this module is absent.
// Ports:
//   clk   : clock
//   rst   : synchronous active-high reset (clears the count)
//   clr   : synchronous clear, takes priority over counting
//   en    : count enable, one increment per enabled cycle
//   count : current count, sticks at all-ones once reached
// ---------------------------------------------------------------------------
`ifdef SA_PERF_CNT_EN
module sa_perf_counter #(
  parameter int W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         clr,
  input  logic         en,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  // Next count: clear wins, otherwise increment unless already saturated.
  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en && (count_q != '1)) begin
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule
`endif

// File: rtl/sa_sequencer.sv
// ---------------------------------------------------------------------------
// sa_sequencer
// Control FSM for the 4x4 systolic matmul datapath. Walks an instruction
// list; each nonzero entry K runs one operation: clear the PE accumulators,
// stream K+2*(DIM-1) pre-skewed operand columns from memA/memB, then commit
// the DIM*DIM results to output memory. A zero entry or the end of the list
// finishes the run and raises ap_done.
// Optional feature macro: SA_PERF_CNT_EN (busy-cycle counter on perf_cycles).
// Ports:
//   clk, rst          : clock, synchronous active-high reset
//   ap_start          : start pulse, accepted only in IDLE or DONE
//   ap_done           : level, high while in DONE
//   busy              : high in every state except IDLE and DONE
//   instr_rd/addr     : instruction memory read strobe and address
//   instr_data        : instruction value, valid the cycle after instr_rd
//   op_rd_en, op_col  : memA/memB read strobe and column address
//   pe_clr, pe_en     : PE accumulator clear and compute enable
//   o_wr_en, o_base   : output-memory commit strobe and base address
//   cur_k             : K of the operation in progress (held afterwards)
//   perf_cycles       : busy-cycle count, or zero without SA_PERF_CNT_EN
// ---------------------------------------------------------------------------
module sa_sequencer
  import sa_pkg::*;
#(
  parameter int DIM     = SA_DIM,
  parameter int K_W     = SA_K_W,
  parameter int IADDR_W = SA_IADDR_W,
  parameter int COL_W   = SA_COL_W,
  parameter int OADDR_W = SA_OADDR_W
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 ap_start,
  output logic                 ap_done,
  output logic                 busy,
  output logic                 instr_rd,
  output logic [IADDR_W-1:0]   instr_addr,
  input  logic [K_W-1:0]       instr_data,
  output logic                 op_rd_en,
  output logic [COL_W-1:0]     op_col,
  output logic                 pe_clr,
  output logic                 pe_en,
  output logic                 o_wr_en,
  output logic [OADDR_W-1:0]   o_base,
  output logic [K_W-1:0]       cur_k,
  output logic [SA_PERF_W-1:0] perf_cycles
);

  localparam int SKEW   = 2 * (DIM - 1);
  localparam int FEED_W = $clog2((2 ** K_W) + SKEW);

  sa_state_t            state_q, state_d;
  logic [IADDR_W-1:0]   ptr_q, ptr_d;
  logic [COL_W-1:0]     col_q, col_d;
  logic [OADDR_W-1:0]   o_base_q, o_base_d;
  logic [K_W-1:0]       cur_k_q, cur_k_d;
  logic [FEED_W-1:0]    feed_q, feed_d;
  logic                 pe_en_q, pe_en_d;

  // Next-state, pointer updates and Moore outputs.
  // The feed counter is loaded with L-1 so that FEED lasts exactly L cycles,
  // leaving for LAST when it reads zero. Starting a run (from IDLE or DONE)
  // rewinds every pointer so each run begins at instruction 0, column 0.
  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    col_d     = col_q;
    o_base_d  = o_base_q;
    cur_k_d   = cur_k_q;
    feed_d    = feed_q;
    pe_en_d   = 1'b0;
    ap_done   = 1'b0;
    busy      = 1'b0;
    instr_rd  = 1'b0;
    op_rd_en  = 1'b0;
    pe_clr    = 1'b0;
    o_wr_en   = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (ap_start) begin
          ptr_d    = '0;
          col_d    = '0;
          o_base_d = '0;
          state_d  = ST_FETCH;
        end
      end
      ST_FETCH: begin
        busy     = 1'b1;
        instr_rd = 1'b1;
        state_d  = ST_DECODE;
      end
      ST_DECODE: begin
        busy = 1'b1;
        if (instr_data == '0) begin
          state_d = ST_DONE;
        end else begin
          cur_k_d = instr_data;
          feed_d  = FEED_W'(instr_data) + FEED_W'(SKEW - 1);
          state_d = ST_CLEAR;
        end
      end
      ST_CLEAR: begin
        busy    = 1'b1;
        pe_clr  = 1'b1;
        state_d = ST_FEED;
      end
      ST_FEED: begin
        busy     = 1'b1;
        op_rd_en = 1'b1;
        pe_en_d  = 1'b1;
        col_d    = col_q + COL_W'(1);
        if (feed_q == '0) begin
          state_d = ST_LAST;
        end else begin
          feed_d = feed_q - FEED_W'(1);
        end
      end
      ST_LAST: begin
        busy    = 1'b1;
        state_d = ST_WRITE;
      end
      ST_WRITE: begin
        busy     = 1'b1;
        o_wr_en  = 1'b1;
        o_base_d = o_base_q + OADDR_W'(DIM * DIM);
        ptr_d    = ptr_q + IADDR_W'(1);
        // Last list slot just executed: the pointer wraps, so stop here
        // instead of fetching the list again.
        if (ptr_q == '1) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_FETCH;
        end
      end
      ST_DONE: begin
        ap_done = 1'b1;
        if (ap_start) begin
          ptr_d    = '0;
          col_d    = '0;
          o_base_d = '0;
          state_d  = ST_FETCH;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  // State and pointer registers. pe_en_q is op_rd_en delayed by one cycle
  // to line up with the one-cycle read latency of memA/memB.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      ptr_q    <= '0;
      col_q    <= '0;
      o_base_q <= '0;
      cur_k_q  <= '0;
      feed_q   <= '0;
      pe_en_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      ptr_q    <= ptr_d;
      col_q    <= col_d;
      o_base_q <= o_base_d;
      cur_k_q  <= cur_k_d;
      feed_q   <= feed_d;
      pe_en_q  <= pe_en_d;
    end
  end

  assign instr_addr = ptr_q;
  assign op_col     = col_q;
  assign o_base     = o_base_q;
  assign cur_k      = cur_k_q;
  assign pe_en      = pe_en_q;

`ifdef SA_PERF_CNT_EN
  // The count restarts whenever a start pulse is actually accepted.
  logic perf_clr;
  assign perf_clr = ap_start && ((state_q == ST_IDLE) || (state_q == ST_DONE));

  sa_perf_counter #(
    .W (SA_PERF_W)
  ) u_perf_counter (
    .clk   (clk),
    .rst   (rst),
    .clr   (perf_clr),
    .en    (busy),
    .count (perf_cycles)
  );
`else
  assign perf_cycles = '0;
`endif

endmodule
